// File: rtl/encoder_read_arbiter_if.sv
// Signal bundle between the encoder read arbiter, the four PID loops and the shared I2C master.
// The arbiter takes the master modport; the PID/I2C side takes the slave modport.
interface encoder_read_arbiter_if;
  logic [3:0]  ch_enable;
  logic [3:0]  prio_req;
  logic        err_clear;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_error;
  logic [11:0] i2c_rdata;
  logic        i2c_start;
  logic [1:0]  dev_sel;
  logic [47:0] angle_out;
  logic [3:0]  rd_done;
  logic [3:0]  timeout_err;
  logic [1:0]  active_ch;

  modport master (
    input  ch_enable, prio_req, err_clear, i2c_busy, i2c_done, i2c_error, i2c_rdata,
    output i2c_start, dev_sel, angle_out, rd_done, timeout_err, active_ch
  );

  modport slave (
    output ch_enable, prio_req, err_clear, i2c_busy, i2c_done, i2c_error, i2c_rdata,
    input  i2c_start, dev_sel, angle_out, rd_done, timeout_err, active_ch
  );
endinterface

// File: rtl/encoder_read_arbiter.sv
// Shares one I2C master among four wheel-encoder channels: round-robin polling with priority
// requests, per-channel angle latching with a read-done strobe, and hang recovery.
module encoder_read_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  encoder_read_arbiter_if.master bus
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT,
    UPDATE,
    RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    dev_sel_q, dev_sel_d;
  logic [1:0]    active_ch_q, active_ch_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [11:0]   hold_q, hold_d;
  logic [47:0]   angle_q, angle_d;
  logic [3:0]    rd_done_q, rd_done_d;
  logic [3:0]    timeout_err_q, timeout_err_d;
  logic [3:0]    prio_pend_q, prio_pend_d;
  logic          start_q, start_d;
  logic [3:0]    pend_clr;
  logic [3:0]    err_set;
  logic [1:0]    next_ch;

  // Pending priority (lowest index) beats round-robin; the round-robin scan starts one past
  // the last serviced channel and reaches that channel itself last.
  function automatic logic [1:0] pick_channel(input logic [3:0] en, input logic [3:0] pend,
                                              input logic [1:0] last);
    logic [3:0] hot;
    logic [1:0] sel;
    logic       found;
    hot   = en & pend;
    sel   = last;
    found = 1'b0;
    if (hot != '0) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!found && hot[i]) begin
          sel   = 2'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 1; i <= 4; i++) begin
        if (!found && en[last + 2'(i)]) begin
          sel   = last + 2'(i);
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d     = state_q;
    dev_sel_d   = dev_sel_q;
    active_ch_d = active_ch_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    hold_d      = hold_q;
    angle_d     = angle_q;
    rd_done_d   = '0;
    start_d     = 1'b0;
    pend_clr    = '0;
    err_set     = '0;
    next_ch     = pick_channel(bus.ch_enable, prio_pend_q, active_ch_q);

    case (state_q)
      IDLE: begin
        // Holding off while the bus is busy keeps dev_sel stable under a live transfer.
        if (bus.ch_enable != '0 && !bus.i2c_busy) begin
          dev_sel_d   = next_ch;
          active_ch_d = next_ch;
          settle_d    = '0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = START;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      START: begin
        if (!bus.i2c_busy) begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.i2c_error) begin
          state_d = IDLE;
        end else if (bus.i2c_done) begin
          hold_d  = bus.i2c_rdata;
          state_d = UPDATE;
        end else if (tmo_q == TIMEOUT_LAST) begin
          err_set[active_ch_q]  = 1'b1;
          pend_clr[active_ch_q] = 1'b1;
          state_d               = RECOVER;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      UPDATE: begin
        pend_clr[active_ch_q] = 1'b1;
        if (bus.ch_enable[active_ch_q]) begin
          angle_d[active_ch_q*12 +: 12] = hold_q;
          rd_done_d[active_ch_q]        = 1'b1;
        end
        state_d = IDLE;
      end
      RECOVER: begin
        if (!bus.i2c_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    prio_pend_d   = (prio_pend_q & ~pend_clr) | bus.prio_req;
    timeout_err_d = (bus.err_clear ? '0 : timeout_err_q) | err_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dev_sel_q     <= '0;
      active_ch_q   <= 2'd3;
      settle_q      <= '0;
      tmo_q         <= '0;
      hold_q        <= '0;
      angle_q       <= '0;
      rd_done_q     <= '0;
      timeout_err_q <= '0;
      prio_pend_q   <= '0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dev_sel_q     <= dev_sel_d;
      active_ch_q   <= active_ch_d;
      settle_q      <= settle_d;
      tmo_q         <= tmo_d;
      hold_q        <= hold_d;
      angle_q       <= angle_d;
      rd_done_q     <= rd_done_d;
      timeout_err_q <= timeout_err_d;
      prio_pend_q   <= prio_pend_d;
      start_q       <= start_d;
    end
  end

  assign bus.i2c_start   = start_q;
  assign bus.dev_sel     = dev_sel_q;
  assign bus.angle_out   = angle_q;
  assign bus.rd_done     = rd_done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.active_ch   = active_ch_q;

endmodule

// File: tb/tb_encoder_read_arbiter.sv
// Self-checking bench for encoder_read_arbiter: I2C slave model plus start-order and
// read-done scoreboards, one task per scenario.
module tb_encoder_read_arbiter;
  localparam int unsigned SETTLE = 8;
  localparam int unsigned TMO    = 100;
  localparam int unsigned LAT    = 20;

  typedef enum int {M_NORMAL, M_HANG, M_COLLIDE} mode_t;
  typedef struct {
    mode_t       mode;
    int unsigned len;
    bit          has_data;
    logic [11:0] data;
  } plan_t;
  typedef struct {
    logic [1:0]  ch;
    logic [11:0] data;
    int unsigned cyc;
  } rd_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  encoder_read_arbiter_if bus ();

  encoder_read_arbiter #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  plan_t       plan_q[$];
  rd_t         rd_q[$];
  logic [1:0]  start_q[$];
  int unsigned n_starts = 0;
  int unsigned n_rd = 0;
  int unsigned last_start_cyc = 0;
  int unsigned busy_fall_cyc = 0;
  int unsigned inject_req = 0;
  logic [11:0] inject_data = '0;

  // I2C master / encoder model: answers each start per the plan queue (default: 0x100+ch after LAT)
  initial begin : i2c_model
    int unsigned inject_ack;
    logic        m_active;
    int unsigned m_cnt, m_len;
    mode_t       m_mode;
    logic [1:0]  m_ch;
    logic [11:0] m_data;
    plan_t       p;
    rd_t         r;
    inject_ack = 0;
    m_active = 1'b0;
    m_cnt = 0; m_len = 0; m_mode = M_NORMAL; m_ch = '0; m_data = '0;
    bus.i2c_busy = 1'b0; bus.i2c_done = 1'b0; bus.i2c_error = 1'b0; bus.i2c_rdata = '0;
    forever begin
      @(negedge clock);
      bus.i2c_done  = 1'b0;
      bus.i2c_error = 1'b0;
      if (!reset_n) begin
        m_active     = 1'b0;
        bus.i2c_busy = 1'b0;
      end else if (inject_req != inject_ack) begin
        inject_ack    = inject_req;
        bus.i2c_done  = 1'b1;
        bus.i2c_rdata = inject_data;
      end else if (m_active) begin
        m_cnt++;
        if (m_cnt == m_len) begin
          m_active      = 1'b0;
          bus.i2c_busy  = 1'b0;
          busy_fall_cyc = cyc;
          if (m_mode != M_HANG) begin
            bus.i2c_done  = 1'b1;
            bus.i2c_rdata = m_data;
          end
          if (m_mode == M_COLLIDE) bus.i2c_error = 1'b1;
          if (m_mode == M_NORMAL && bus.ch_enable[m_ch]) begin
            r.ch = m_ch; r.data = m_data; r.cyc = cyc;
            rd_q.push_back(r);
          end
        end
      end else if (bus.i2c_start === 1'b1) begin
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else begin
          p.mode = M_NORMAL; p.len = LAT; p.has_data = 1'b0; p.data = '0;
        end
        m_active     = 1'b1;
        m_cnt        = 0;
        m_mode       = p.mode;
        m_len        = p.len;
        m_ch         = bus.dev_sel;
        m_data       = p.has_data ? p.data : 12'h100 + 12'(bus.dev_sel);
        bus.i2c_busy = 1'b1;
      end
    end
  end

  // Start monitor: service order, one-cycle start pulse, dev_sel stable while busy
  initial begin : start_mon
    logic [1:0] exp_ch;
    logic [1:0] prev_sel;
    logic       prev_start;
    prev_sel = '0;
    prev_start = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && bus.i2c_start === 1'b1) begin
        last_start_cyc = cyc;
        n_starts++;
        if (start_q.size() > 0) begin
          exp_ch = start_q.pop_front();
          tests_run++;
          if (bus.dev_sel !== exp_ch) begin
            tests_failed++;
            $display("FAIL start_order: dev_sel=%0d expected %0d (cycle %0d)", bus.dev_sel, exp_ch, cyc);
          end
        end
        tests_run++;
        if (prev_start) begin
          tests_failed++;
          $display("FAIL start_width: i2c_start high two cycles running (cycle %0d)", cyc);
        end
      end
      if (reset_n && bus.i2c_busy) begin
        tests_run++;
        if (bus.dev_sel !== prev_sel) begin
          tests_failed++;
          $display("FAIL dev_sel_busy: dev_sel %0d -> %0d while busy", prev_sel, bus.dev_sel);
        end
      end
      prev_sel   = bus.dev_sel;
      prev_start = reset_n && (bus.i2c_start === 1'b1);
    end
  end

  // Read-done monitor: every strobe must match the oldest expected read, two cycles after done
  initial begin : rd_mon
    rd_t         e;
    logic [11:0] got;
    forever begin
      @(negedge clock);
      if (reset_n && bus.rd_done !== 4'b0000) begin
        tests_run++;
        if (rd_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rd_unexpected: rd_done=%b with no read expected (cycle %0d)", bus.rd_done, cyc);
        end else begin
          e   = rd_q.pop_front();
          got = bus.angle_out[int'(e.ch)*12 +: 12];
          n_rd++;
          if (bus.rd_done !== (4'b0001 << e.ch) || got !== e.data || cyc != e.cyc + 2) begin
            tests_failed++;
            $display("FAIL rd_event: rd_done=%b angle=%h lat=%0d expected rd_done=%b angle=%h lat=2",
                     bus.rd_done, got, cyc - e.cyc, 4'b0001 << e.ch, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  task automatic add_plan(input mode_t m, input int unsigned len, input bit hd, input logic [11:0] d);
    plan_t p;
    p.mode = m; p.len = len; p.has_data = hd; p.data = d;
    plan_q.push_back(p);
  endtask

  task automatic wait_starts(input int unsigned n, input int unsigned limit);
    int unsigned k = 0;
    while (n_starts < n && k < limit) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic wait_rd(input int unsigned n, input int unsigned limit);
    int unsigned k = 0;
    while (n_rd < n && k < limit) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    bus.ch_enable = '0;
    bus.prio_req = '0;
    bus.err_clear = 1'b0;
    repeat (3) @(negedge clock);
    start_q.delete();
    rd_q.delete();
    plan_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.i2c_start !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %b expected 0", bus.i2c_start); end
    tests_run++;
    if (bus.dev_sel !== 2'd0) begin tests_failed++; $display("FAIL reset_dev_sel: got %0d expected 0", bus.dev_sel); end
    tests_run++;
    if (bus.angle_out !== 48'h0) begin tests_failed++; $display("FAIL reset_angle: got %h expected 0", bus.angle_out); end
    tests_run++;
    if (bus.rd_done !== 4'b0000) begin tests_failed++; $display("FAIL reset_rd_done: got %b expected 0000", bus.rd_done); end
    tests_run++;
    if (bus.timeout_err !== 4'b0000) begin tests_failed++; $display("FAIL reset_timeout_err: got %b expected 0000", bus.timeout_err); end
    tests_run++;
    if (bus.active_ch !== 2'd3) begin tests_failed++; $display("FAIL reset_active_ch: got %0d expected 3", bus.active_ch); end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    int unsigned r;
    do_reset();
    r = n_rd;
    foreach (order[i]) start_q.push_back(order[i]);
    bus.ch_enable = 4'b1011;
    wait_rd(r + 6, 1000);
    tests_run++;
    if (n_rd < r + 6 || start_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rr_progress: reads=%0d starts_left=%0d expected reads=6 starts_left=0", n_rd - r, start_q.size());
    end
    bus.ch_enable = '0;
    repeat (60) @(negedge clock);
    tests_run++;
    if (bus.angle_out !== 48'h103_000_101_100) begin
      tests_failed++;
      $display("FAIL rr_angles: got %h expected 103000101100", bus.angle_out);
    end
  endtask

  task automatic test_priority();
    int unsigned b, r;
    do_reset();
    b = n_starts; r = n_rd;
    start_q.push_back(2'd0); start_q.push_back(2'd3); start_q.push_back(2'd0); start_q.push_back(2'd1);
    bus.ch_enable = 4'b1111;
    wait_starts(b + 1, 100);
    bus.prio_req = 4'b1000;
    @(negedge clock);
    bus.prio_req = 4'b0000;
    wait_rd(r + 4, 600);
    tests_run++;
    if (n_rd < r + 4 || start_q.size() != 0) begin
      tests_failed++;
      $display("FAIL prio_progress: reads=%0d starts_left=%0d expected reads=4 starts_left=0", n_rd - r, start_q.size());
    end
    bus.ch_enable = '0;
    repeat (60) @(negedge clock);
    tests_run++;
    if (bus.angle_out[47:36] !== 12'h103) begin
      tests_failed++;
      $display("FAIL prio_angle3: got %h expected 103", bus.angle_out[47:36]);
    end
  endtask

  task automatic test_timeout();
    int unsigned b, r, s;
    do_reset();
    b = n_starts; r = n_rd;
    add_plan(M_HANG, 150, 1'b0, 12'h000);
    start_q.push_back(2'd2); start_q.push_back(2'd2);
    bus.ch_enable = 4'b0100;
    wait_starts(b + 1, 100);
    tests_run++;
    if (n_starts < b + 1) begin tests_failed++; $display("FAIL tmo_first_start: got %0d starts expected 1", n_starts - b); end
    s = last_start_cyc;
    while (cyc < s + 99) @(negedge clock);
    tests_run++;
    if (bus.timeout_err !== 4'b0000) begin tests_failed++; $display("FAIL tmo_early: got %b expected 0000", bus.timeout_err); end
    bus.err_clear = 1'b1;
    @(negedge clock);
    bus.err_clear = 1'b0;
    tests_run++;
    if (bus.timeout_err !== 4'b0100) begin tests_failed++; $display("FAIL tmo_flag: got %b expected 0100", bus.timeout_err); end
    wait_starts(b + 2, 200);
    tests_run++;
    if (n_starts < b + 2 || last_start_cyc <= busy_fall_cyc) begin
      tests_failed++;
      $display("FAIL tmo_restart: start at %0d busy fell at %0d expected start after busy fall", last_start_cyc, busy_fall_cyc);
    end
    wait_rd(r + 1, 200);
    bus.ch_enable = '0;
    repeat (60) @(negedge clock);
    tests_run++;
    if (n_rd != r + 1 || bus.angle_out[35:24] !== 12'h102) begin
      tests_failed++;
      $display("FAIL tmo_reread: reads=%0d angle2=%h expected reads=1 angle2=102", n_rd - r, bus.angle_out[35:24]);
    end
    tests_run++;
    if (bus.timeout_err !== 4'b0100) begin tests_failed++; $display("FAIL tmo_sticky: got %b expected 0100", bus.timeout_err); end
    bus.err_clear = 1'b1;
    @(negedge clock);
    bus.err_clear = 1'b0;
    tests_run++;
    if (bus.timeout_err !== 4'b0000) begin tests_failed++; $display("FAIL tmo_clear: got %b expected 0000", bus.timeout_err); end
  endtask

  task automatic test_collision();
    int unsigned r;
    do_reset();
    r = n_rd;
    add_plan(M_NORMAL, LAT, 1'b0, 12'h000);
    add_plan(M_NORMAL, LAT, 1'b0, 12'h000);
    add_plan(M_COLLIDE, LAT, 1'b1, 12'hEEE);
    add_plan(M_NORMAL, LAT, 1'b0, 12'h000);
    start_q.push_back(2'd1); start_q.push_back(2'd2); start_q.push_back(2'd1); start_q.push_back(2'd2);
    bus.ch_enable = 4'b0110;
    wait_rd(r + 3, 600);
    tests_run++;
    if (n_rd < r + 3 || start_q.size() != 0) begin
      tests_failed++;
      $display("FAIL coll_progress: reads=%0d starts_left=%0d expected reads=3 starts_left=0", n_rd - r, start_q.size());
    end
    bus.ch_enable = '0;
    repeat (60) @(negedge clock);
    tests_run++;
    if (bus.angle_out[23:12] !== 12'h101) begin tests_failed++; $display("FAIL coll_angle1: got %h expected 101", bus.angle_out[23:12]); end
  endtask

  task automatic test_disable_mid_read();
    int unsigned b, r;
    do_reset();
    b = n_starts; r = n_rd;
    add_plan(M_NORMAL, LAT, 1'b0, 12'h000);
    add_plan(M_NORMAL, LAT, 1'b1, 12'hABC);
    start_q.push_back(2'd0); start_q.push_back(2'd0);
    bus.ch_enable = 4'b0001;
    wait_starts(b + 2, 200);
    repeat (5) @(negedge clock);
    bus.ch_enable = 4'b0000;
    repeat (60) @(negedge clock);
    tests_run++;
    if (n_rd != r + 1 || bus.angle_out[11:0] !== 12'h100) begin
      tests_failed++;
      $display("FAIL dis_discard: reads=%0d angle0=%h expected reads=1 angle0=100", n_rd - r, bus.angle_out[11:0]);
    end
    r = n_rd;
    start_q.push_back(2'd1); start_q.push_back(2'd3); start_q.push_back(2'd1);
    bus.ch_enable = 4'b1010;
    wait_rd(r + 3, 600);
    bus.ch_enable = '0;
    repeat (60) @(negedge clock);
    tests_run++;
    if (start_q.size() != 0 || bus.angle_out !== 48'h103_000_101_100) begin
      tests_failed++;
      $display("FAIL dis_skip: starts_left=%0d angle=%h expected 0 and 103000101100", start_q.size(), bus.angle_out);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned b, r, s1, s2;
    do_reset();
    b = n_starts; r = n_rd;
    start_q.push_back(2'd0); start_q.push_back(2'd0); start_q.push_back(2'd0);
    bus.ch_enable = 4'b0001;
    wait_starts(b + 1, 100);
    s1 = last_start_cyc;
    wait_starts(b + 2, 100);
    s2 = last_start_cyc;
    tests_run++;
    if (n_starts < b + 2 || s2 - s1 < SETTLE + 3 + LAT || s2 - s1 > SETTLE + 4 + LAT) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d cycles expected %0d..%0d", s2 - s1, SETTLE + 3 + LAT, SETTLE + 4 + LAT);
    end
    wait_rd(r + 3, 200);
    tests_run++;
    if (n_rd < r + 3) begin tests_failed++; $display("FAIL b2b_reads: got %0d expected 3", n_rd - r); end
    bus.ch_enable = '0;
    repeat (60) @(negedge clock);
  endtask

  task automatic test_async_reset();
    int unsigned b, r;
    do_reset();
    b = n_starts; r = n_rd;
    add_plan(M_NORMAL, LAT, 1'b0, 12'h000);
    add_plan(M_HANG, 1000, 1'b0, 12'h000);
    start_q.push_back(2'd0); start_q.push_back(2'd0);
    bus.ch_enable = 4'b0001;
    wait_starts(b + 2, 200);
    repeat (5) @(negedge clock);
    tests_run++;
    if (bus.angle_out[11:0] !== 12'h100) begin tests_failed++; $display("FAIL ar_pre_angle: got %h expected 100", bus.angle_out[11:0]); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.angle_out !== 48'h0 || bus.dev_sel !== 2'd0 || bus.active_ch !== 2'd3 ||
        bus.i2c_start !== 1'b0 || bus.rd_done !== 4'b0000 || bus.timeout_err !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ar_values: angle=%h dev_sel=%0d active=%0d start=%b rd=%b tmo=%b expected 0/0/3/0/0000/0000",
               bus.angle_out, bus.dev_sel, bus.active_ch, bus.i2c_start, bus.rd_done, bus.timeout_err);
    end
    bus.ch_enable = '0;
    repeat (3) @(negedge clock);
    start_q.delete(); rd_q.delete(); plan_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
    inject_data = 12'h5A5;
    inject_req++;
    repeat (5) @(negedge clock);
    tests_run++;
    if (bus.angle_out !== 48'h0) begin tests_failed++; $display("FAIL ar_stray: got %h expected 0", bus.angle_out); end
    r = n_rd;
    start_q.push_back(2'd0);
    bus.ch_enable = 4'b1111;
    wait_rd(r + 1, 200);
    bus.ch_enable = '0;
    repeat (60) @(negedge clock);
    tests_run++;
    if (start_q.size() != 0 || bus.angle_out !== 48'h000_000_000_100) begin
      tests_failed++;
      $display("FAIL ar_next: starts_left=%0d angle=%h expected 0 and 000000000100", start_q.size(), bus.angle_out);
    end
  endtask

  initial begin : main
    reset_n = 1'b0;
    bus.ch_enable = '0;
    bus.prio_req = '0;
    bus.err_clear = 1'b0;
    test_reset();
    test_round_robin();
    test_priority();
    test_timeout();
    test_collision();
    test_disable_mid_read();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
